cp0_unit: RTL and testbench
===========================

# cp0_unit

Parametrised coprocessor-0 for the five-stage MIPS pipeline, the successor to the fixed six-line CP0. It holds SR, Cause, EPC, BadVAddr, Count, Compare and PRId, and arbitrates between hardware interrupts, an internal Count/Compare timer interrupt and synchronous exceptions. It raises a single flush/redirect request to the pipeline and serves mfc0/mtc0/eret. It sits beside the M stage: all inputs come from the M-stage instruction, and `epc` feeds the eret redirect.

## Interface
- NUM_HWINT, 6: external interrupt lines, 1..6; mapped to Cause.IP/SR.IM bits [10 +: NUM_HWINT]; unused IP/IM bits read 0.
- IRQ_EDGE, 0: 0 = level (IP mirrors lines each cycle); 1 = rising-edge latched (IP bit set on 0→1, cleared only by mtc0 Cause writing 0 to that bit).
- HAS_TIMER, 1: enables Count/Compare; timer pending ORs into IP[15].
- PRID, 32'h0000_2023: PRId read value.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low: reset==0 at a rising edge resets all state.
- we  in  1  mtc0 write strobe.
- addr  in  5  CP0 register number for read and write.
- wdata  in  32  mtc0 data.
- rdata  out  32  mfc0 data, combinational.
- vpc  in  32  PC of the M-stage instruction.
- vpc_valid  in  1  M stage holds a real instruction, not a bubble; interrupts are taken only when 1.
- bd  in  1  M-stage instruction is in a delay slot.
- exc  in  1  synchronous exception present.
- exc_code  in  5  ExcCode of that exception.
- bad_vaddr  in  32  faulting address for AdEL/AdES.
- hwint  in  NUM_HWINT  external interrupt lines.
- eret  in  1  eret in M.
- req  out  1  take exception/interrupt this cycle; pipeline flushes and jumps to handler 0x4180.
- epc  out  32  current EPC.

## Operation
- Registers: 8 BadVAddr (RO), 9 Count, 11 Compare, 12 SR (IE bit0, EXL bit1, IM 15:10), 13 Cause (ExcCode 6:2, IP 15:10, BD 31), 14 EPC, 15 PRId (RO). Unmapped addr reads 0; writes to RO/unmapped addr are ignored.
- Writable bits: SR[0], SR[1] and IM bits that exist; EPC is fully writable. Cause accepts writes only to IP bits in edge mode. All other bits read 0.
- int_pend = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL & vpc_valid.
- req = int_pend | (exc & ~SR.EXL). Interrupt has priority over a simultaneous exception.
- On a clock edge with req=1:
  - EXL←1; BD←bd; EPC←bd ? vpc-4 : vpc.
  - ExcCode←0 for an interrupt, otherwise exc_code.
  - BadVAddr←bad_vaddr only if the exception is taken and exc_code is 4 or 5.
  - A same-cycle mtc0 is discarded.
- eret with EXL=1: EXL←0 at the edge. If mtc0 SR is in the same cycle, the write applies first, then EXL is forced to 0. eret with EXL=0 is a no-op.
- With EXL=1, req stays 0 and nothing is logged. Cause.IP keeps tracking per IRQ_EDGE.
- Timer (HAS_TIMER=1):
  - Count increments every cycle and wraps 2^32-1→0. mtc0 Count loads wdata, which replaces that cycle's increment.
  - When Count==Compare, the timer pending flag sets on the next edge. A write to Compare clears it.
  - HAS_TIMER=0: Count and Compare read 0 and IP[15] comes from hwint only.

## Timing
- Reset values: SR, Cause, EPC, BadVAddr, Count, Compare and the timer flag are 0; req=0; epc=0; rdata=0, except PRID when addr=15.
- req and rdata are combinational from the current state and inputs. All state updates happen at the next rising edge.
- mtc0 is visible to mfc0 in the following cycle; there is no internal write→read forwarding.
- Level IP reflects hwint with a one-cycle register delay. An interrupt asserted in cycle n can raise req in cycle n+1.
- Reset asserted mid-handler clears EXL and any pending state immediately at that edge.

## Structure
- Package cp0_pkg holds:
  - register number constants;
  - ExcCode localparams: Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12;
  - SR/Cause bit positions and the handler address 32'h0000_4180.
- Sub-module cp0_timer holds Count, Compare, the match flag and the write ports.

## Test plan
- Reset (reset=0 for one cycle) → mfc0 12/13/14/9 return 0, addr 15 returns 32'h0000_2023, req=0.
- Set SR=32'h0000_0401, drive hwint[0]=1 with vpc=0x3008, vpc_valid=1, bd=0 → req=1; the next cycle shows EXL=1, Cause=0x0000_0400, EPC=0x3008. With bd=1, EPC=0x3004 and Cause[31]=1.
- exc=1, exc_code=4, bad_vaddr=0x1001, vpc=0x3010 with IE=0 → req=1; Cause[6:2]=4, BadVAddr=0x1001, EPC=0x3010. A second exception while EXL=1 gives req=0 and no register changes.
- Interrupt and exception in the same cycle (IM/IE set) → ExcCode=0 and BadVAddr unchanged. A simultaneous mtc0 EPC=0xFFFF is discarded.
- Timer: write Compare=20, Count=10, SR=32'h0000_8001 → req rises 11 cycles after the Count write. Writing Compare clears the pending flag; IP[15]=0 the next cycle.
- IRQ_EDGE=1: pulse hwint[2] for one cycle with IM clear → IP[12] stays 1. mtc0 Cause=0 clears it. A held-high line does not re-set IP until it goes 0→1 again.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and bit positions
package cp0_pkg;

   // CP0 register numbers
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   // ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR / Cause bit positions
   localparam int SR_IE       = 0;
   localparam int SR_EXL      = 1;
   localparam int IM_LSB      = 10;
   localparam int IP_LSB      = 10;
   localparam int EXCCODE_LSB = 2;
   localparam int CAUSE_BD    = 31;
   localparam int TIMER_IP    = 5;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

   // What the unit takes on the current cycle
   typedef enum logic [1:0] {
      TAKE_NONE = 2'd0,
      TAKE_INT  = 2'd1,
      TAKE_EXC  = 2'd2
   } take_e;

   // Address-error exceptions are the only ones that log BadVAddr
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with sticky match flag
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        pending
);
   import cp0_pkg::*;

   // Count free-runs (a write replaces the increment); match sets the flag, a Compare write clears it
   always_ff @(posedge clk) begin
      if (!reset) begin
         count   <= '0;
         compare <= '0;
         pending <= 1'b0;
      end else begin
         count <= count_we ? wdata : count + 32'd1;
         if (compare_we) begin
            compare <= wdata;
            pending <= 1'b0;
         end else if (count == compare) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor 0: status, cause, EPC, timer and trap arbitration
module cp0_unit #(
   parameter int          NUM_HWINT = 6,
   parameter int          IRQ_EDGE  = 0,
   parameter int          HAS_TIMER = 1,
   parameter logic [31:0] PRID      = 32'h0000_2023
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [4:0]           addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic [31:0]          vpc,
   input  logic                 vpc_valid,
   input  logic                 bd,
   input  logic                 exc,
   input  logic [4:0]           exc_code,
   input  logic [31:0]          bad_vaddr,
   input  logic [NUM_HWINT-1:0] hwint,
   input  logic                 eret,
   output logic                 req,
   output logic [31:0]          epc
);
   import cp0_pkg::*;

   // IP/IM bits that physically exist; the timer owns IP[15] when present
   localparam int          HW_MASK_I = (1 << NUM_HWINT) - 1;
   localparam logic [5:0]  HW_MASK   = HW_MASK_I[5:0];
   localparam logic [5:0]  TMR_MASK  = (HAS_TIMER != 0) ? 6'b10_0000 : 6'b00_0000;
   localparam logic [5:0]  IM_MASK   = HW_MASK | TMR_MASK;

   logic        sr_ie;
   logic        sr_exl;
   logic [5:0]  sr_im;
   logic        cause_bd;
   logic [4:0]  cause_code;
   logic [5:0]  ip_hw;
   logic [5:0]  hw_prev;
   logic [31:0] epc_q;
   logic [31:0] badvaddr_q;

   logic [5:0]  hw_ext;
   logic [5:0]  ip_vec;
   logic        int_pend;
   logic        take_exc;
   take_e       take;
   logic        wr_ok;
   logic        count_we;
   logic        compare_we;
   logic [31:0] count_v;
   logic [31:0] compare_v;
   logic        timer_pend;

   // Widen the interrupt lines to the six-bit IP field
   always_comb begin
      hw_ext = '0;
      hw_ext[NUM_HWINT-1:0] = hwint;
   end

   assign ip_vec   = ip_hw | ((timer_pend && (HAS_TIMER != 0)) ? 6'b10_0000 : 6'b00_0000);
   assign int_pend = (|(ip_vec & sr_im)) & sr_ie & ~sr_exl & vpc_valid;
   assign take_exc = exc & ~sr_exl;
   assign req      = int_pend | take_exc;
   assign epc      = epc_q;

   // Interrupts win over a simultaneous synchronous exception
   always_comb begin
      take = TAKE_NONE;
      if (int_pend) begin
         take = TAKE_INT;
      end else if (take_exc) begin
         take = TAKE_EXC;
      end
   end

   // A trap in the same cycle swallows any mtc0
   assign wr_ok      = we & ~req;
   assign count_we   = wr_ok && (addr == REG_COUNT);
   assign compare_we = wr_ok && (addr == REG_COMPARE);

   generate
      if (HAS_TIMER != 0) begin : g_timer
         cp0_timer u_timer (
            .clk        (clk),
            .reset      (reset),
            .count_we   (count_we),
            .compare_we (compare_we),
            .wdata      (wdata),
            .count      (count_v),
            .compare    (compare_v),
            .pending    (timer_pend)
         );
      end else begin : g_no_timer
         assign count_v    = '0;
         assign compare_v  = '0;
         assign timer_pend = 1'b0;
      end
   endgenerate

   // Hardware IP bits: level mirrors the lines, edge latches 0->1 until software clears
   always_ff @(posedge clk) begin
      if (!reset) begin
         ip_hw   <= '0;
         hw_prev <= '0;
      end else begin
         hw_prev <= hw_ext;
         if (IRQ_EDGE != 0) begin
            if (wr_ok && (addr == REG_CAUSE)) begin
               ip_hw <= (wdata[IP_LSB +: 6] & HW_MASK) | (hw_ext & ~hw_prev);
            end else begin
               ip_hw <= ip_hw | (hw_ext & ~hw_prev);
            end
         end else begin
            ip_hw <= hw_ext;
         end
      end
   end

   // SR, Cause, EPC and BadVAddr: trap logging first, else mtc0 then eret
   always_ff @(posedge clk) begin
      if (!reset) begin
         sr_ie      <= 1'b0;
         sr_exl     <= 1'b0;
         sr_im      <= '0;
         cause_bd   <= 1'b0;
         cause_code <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else if (take != TAKE_NONE) begin
         sr_exl   <= 1'b1;
         cause_bd <= bd;
         epc_q    <= bd ? (vpc - 32'd4) : vpc;
         if (take == TAKE_INT) begin
            cause_code <= EXC_INT;
         end else begin
            cause_code <= exc_code;
            if (is_addr_exc(exc_code)) begin
               badvaddr_q <= bad_vaddr;
            end
         end
      end else begin
         if (we) begin
            case (addr)
               REG_SR: begin
                  sr_ie  <= wdata[SR_IE];
                  sr_exl <= wdata[SR_EXL];
                  sr_im  <= wdata[IM_LSB +: 6] & IM_MASK;
               end
               REG_EPC: epc_q <= wdata;
               default: ;
            endcase
         end
         if (eret && sr_exl) begin
            sr_exl <= 1'b0;
         end
      end
   end

   // mfc0 read mux; unused bits and unmapped registers read 0
   always_comb begin
      rdata = '0;
      case (addr)
         REG_BADVADDR: rdata = badvaddr_q;
         REG_COUNT:    rdata = count_v;
         REG_COMPARE:  rdata = compare_v;
         REG_SR:       rdata = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
         REG_CAUSE:    rdata = {cause_bd, 15'b0, ip_vec, 3'b0, cause_code, 2'b0};
         REG_EPC:      rdata = epc_q;
         REG_PRID:     rdata = PRID;
         default:      rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed vector bench for cp0_unit
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] vpc;
   logic        vpc_valid;
   logic        bd;
   logic        exc;
   logic [4:0]  exc_code;
   logic [31:0] bad_vaddr;
   logic [5:0]  hwint;
   logic        eret;

   logic [31:0] rdata;
   logic        req;
   logic [31:0] epc;
   logic [31:0] rdata_e;
   logic        req_e;
   logic [31:0] epc_e;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cp0_unit #(.NUM_HWINT(6), .IRQ_EDGE(0), .HAS_TIMER(1), .PRID(32'h0000_2023)) u_dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
      .vpc(vpc), .vpc_valid(vpc_valid), .bd(bd), .exc(exc), .exc_code(exc_code),
      .bad_vaddr(bad_vaddr), .hwint(hwint), .eret(eret), .req(req), .epc(epc)
   );

   cp0_unit #(.NUM_HWINT(6), .IRQ_EDGE(1), .HAS_TIMER(1), .PRID(32'h0000_2023)) u_edge (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata_e),
      .vpc(vpc), .vpc_valid(vpc_valid), .bd(bd), .exc(exc), .exc_code(exc_code),
      .bad_vaddr(bad_vaddr), .hwint(hwint), .eret(eret), .req(req_e), .epc(epc_e)
   );

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] vpc;
      logic        vv;
      logic        bd;
      logic        exc;
      logic [4:0]  ec;
      logic [31:0] bva;
      logic [5:0]  hw;
      logic        eret;
      logic        x_req;
      logic [31:0] x_rd;
      logic [31:0] x_epc;
   } vec_t;

   vec_t vecs[32];

   function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a, input logic [31:0] wd,
                               input logic [31:0] pc, input logic v, input logic b, input logic e,
                               input logic [4:0] c, input logic [31:0] ba, input logic [5:0] h,
                               input logic er, input logic xr, input logic [31:0] xd, input logic [31:0] xe);
      vec_t t;
      t.rst = r; t.we = w; t.addr = a; t.wdata = wd; t.vpc = pc; t.vv = v; t.bd = b; t.exc = e;
      t.ec = c; t.bva = ba; t.hw = h; t.eret = er; t.x_req = xr; t.x_rd = xd; t.x_epc = xe;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = '0; vpc = '0; vpc_valid = 1'b0;
      bd = 1'b0; exc = 1'b0; exc_code = '0; bad_vaddr = '0; hwint = '0; eret = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      vecs[0]  = mk(0,0,5'd12,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h0);
      vecs[1]  = mk(0,0,5'd13,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h0);
      vecs[2]  = mk(0,0,5'd14,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h0);
      vecs[3]  = mk(0,0,5'd9, 32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h0);
      vecs[4]  = mk(0,0,5'd15,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0000_2023,32'h0);
      vecs[5]  = mk(0,0,5'd8, 32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h0);
      vecs[6]  = mk(1,1,5'd11,32'hFFFF_0000,32'h0,  0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h0);
      vecs[7]  = mk(1,0,5'd11,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'hFFFF_0000,32'h0);
      vecs[8]  = mk(1,1,5'd12,32'h401,     32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h0);
      vecs[9]  = mk(1,0,5'd13,32'h0,       32'h3008,1,0,0,5'd0,32'h0,   6'd1,0, 0,32'h0,        32'h0);
      vecs[10] = mk(1,0,5'd13,32'h0,       32'h3008,1,0,0,5'd0,32'h0,   6'd1,0, 1,32'h400,      32'h0);
      vecs[11] = mk(1,0,5'd12,32'h0,       32'h3008,1,0,0,5'd0,32'h0,   6'd1,0, 0,32'h403,      32'h3008);
      vecs[12] = mk(1,0,5'd13,32'h0,       32'h3008,1,0,0,5'd0,32'h0,   6'd1,0, 0,32'h400,      32'h3008);
      vecs[13] = mk(1,0,5'd14,32'h0,       32'h3008,1,0,0,5'd0,32'h0,   6'd1,0, 0,32'h3008,     32'h3008);
      vecs[14] = mk(1,0,5'd12,32'h0,       32'h3008,1,0,0,5'd0,32'h0,   6'd0,1, 0,32'h403,      32'h3008);
      vecs[15] = mk(1,0,5'd12,32'h0,       32'h3008,1,1,0,5'd0,32'h0,   6'd1,0, 0,32'h401,      32'h3008);
      vecs[16] = mk(1,0,5'd13,32'h0,       32'h3008,1,1,0,5'd0,32'h0,   6'd1,0, 1,32'h400,      32'h3008);
      vecs[17] = mk(1,0,5'd13,32'h0,       32'h3008,1,1,0,5'd0,32'h0,   6'd1,0, 0,32'h8000_0400,32'h3004);
      vecs[18] = mk(1,1,5'd12,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,1, 0,32'h403,      32'h3004);
      vecs[19] = mk(1,0,5'd8, 32'h0,       32'h3010,1,0,1,5'd4,32'h1001,6'd0,0, 1,32'h0,        32'h3004);
      vecs[20] = mk(1,0,5'd13,32'h0,       32'h3020,1,0,1,5'd5,32'h2222,6'd0,0, 0,32'h10,       32'h3010);
      vecs[21] = mk(1,0,5'd8, 32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h1001,     32'h3010);
      vecs[22] = mk(1,0,5'd12,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h2,        32'h3010);
      vecs[23] = mk(1,1,5'd12,32'h401,     32'h0,   0,0,0,5'd0,32'h0,   6'd0,1, 0,32'h2,        32'h3010);
      vecs[24] = mk(1,0,5'd13,32'h0,       32'h0,   1,0,0,5'd0,32'h0,   6'd1,0, 0,32'h10,       32'h3010);
      vecs[25] = mk(1,1,5'd14,32'hFFFF,    32'h3040,1,0,1,5'd5,32'h5555,6'd1,0, 1,32'h3010,     32'h3010);
      vecs[26] = mk(1,0,5'd14,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h3040,     32'h3040);
      vecs[27] = mk(1,0,5'd8, 32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h1001,     32'h3040);
      vecs[28] = mk(1,0,5'd13,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h3040);
      vecs[29] = mk(1,1,5'd15,32'h1234,    32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0000_2023,32'h3040);
      vecs[30] = mk(1,0,5'd15,32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0000_2023,32'h3040);
      vecs[31] = mk(1,0,5'd3, 32'h0,       32'h0,   0,0,0,5'd0,32'h0,   6'd0,0, 0,32'h0,        32'h3040);

      idle();
      tick();
      do_reset();
      reset = 1'b0;

      for (int i = 0; i < 32; i++) begin
         reset = vecs[i].rst; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
         vpc = vecs[i].vpc; vpc_valid = vecs[i].vv; bd = vecs[i].bd; exc = vecs[i].exc;
         exc_code = vecs[i].ec; bad_vaddr = vecs[i].bva; hwint = vecs[i].hw; eret = vecs[i].eret;
         settle();
         chk($sformatf("v%0d.req", i),   {31'b0, req}, {31'b0, vecs[i].x_req});
         chk($sformatf("v%0d.rdata", i), rdata,        vecs[i].x_rd);
         chk($sformatf("v%0d.epc", i),   epc,          vecs[i].x_epc);
         tick();
      end

      // Timer: Compare=20, Count=10, then enable IM[15]/IE
      do_reset();
      we = 1'b1; addr = 5'd11; wdata = 32'd20;
      tick();
      addr = 5'd9; wdata = 32'd10;
      tick();
      addr = 5'd12; wdata = 32'h0000_8001; vpc_valid = 1'b1; vpc = 32'h5000;
      settle();
      chk("tmr.req0", {31'b0, req}, 32'd0);
      tick();
      we = 1'b0; addr = 5'd9;
      for (int k = 1; k <= 10; k++) begin
         settle();
         chk($sformatf("tmr.req%0d", k),   {31'b0, req}, 32'd0);
         chk($sformatf("tmr.count%0d", k), rdata,        32'd10 + k);
         tick();
      end
      addr = 5'd13;
      settle();
      chk("tmr.req_rise", {31'b0, req}, 32'd1);
      chk("tmr.ip15",     rdata,        32'h0000_8000);
      tick();
      settle();
      chk("tmr.held_exl", {31'b0, req}, 32'd0);
      chk("tmr.ip15_pend", rdata,       32'h0000_8000);
      chk("tmr.epc",      epc,          32'h5000);
      tick();
      we = 1'b1; addr = 5'd11; wdata = 32'd100;
      settle();
      chk("tmr.cmp_read", rdata, 32'd20);
      tick();
      we = 1'b0; addr = 5'd13;
      settle();
      chk("tmr.ip15_clr", rdata, 32'h0);
      tick();

      // Edge-latched interrupts on the IRQ_EDGE=1 instance
      do_reset();
      we = 1'b1; addr = 5'd11; wdata = 32'hFFFF_0000; hwint = 6'b000100;
      tick();
      we = 1'b0; addr = 5'd13; hwint = 6'b0;
      settle();
      chk("edg.latch",     rdata_e, 32'h0000_1000);
      chk("lvl.follow",    rdata,   32'h0000_1000);
      tick();
      settle();
      chk("edg.sticky",    rdata_e, 32'h0000_1000);
      chk("lvl.drop",      rdata,   32'h0);
      chk("edg.no_req",    {31'b0, req_e}, 32'd0);
      tick();
      we = 1'b1; wdata = 32'h0;
      settle();
      chk("edg.pre_clr",   rdata_e, 32'h0000_1000);
      tick();
      we = 1'b0; hwint = 6'b000100;
      settle();
      chk("edg.cleared",   rdata_e, 32'h0);
      tick();
      settle();
      chk("edg.relatch",   rdata_e, 32'h0000_1000);
      tick();
      we = 1'b1; wdata = 32'h0;
      tick();
      we = 1'b0;
      settle();
      chk("edg.held_a",    rdata_e, 32'h0);
      tick();
      settle();
      chk("edg.held_b",    rdata_e, 32'h0);
      tick();
      hwint = 6'b0;
      settle();
      chk("edg.low",       rdata_e, 32'h0);
      tick();
      hwint = 6'b000100;
      settle();
      chk("edg.rise_pre",  rdata_e, 32'h0);
      tick();
      settle();
      chk("edg.rise_post", rdata_e, 32'h0000_1000);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
